// File: rtl/mem_responder_pkg.sv
// Shared encodings and constants for the mem_responder bus slave.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [15:0] VEC_NMI_ADDR  = 16'hFFFA;
    localparam logic [15:0] VEC_RST_ADDR  = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_ADDR  = 16'hFFFE;
    localparam logic [7:0]  UNMAPPED_DATA = 8'hFF;

    function automatic logic is_vector(input logic [15:0] addr);
        return addr >= VEC_NMI_ADDR;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Byte-wide RAM: one synchronous write port, asynchronous read.
module mem_array #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// CPU-side memory responder: RAM, vector ROM and wait-state handshake.
//   state     | meaning
//   ST_IDLE   | latch address/rw/sync every edge, start a transfer
//   ST_WAIT   | wait counter running down to its terminal count
//   ST_ACCESS | single transfer cycle, rdy=1, data driven on reads
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          RAM_DEPTH   = 512,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] NMI_VEC     = 16'h0200,
    parameter logic [15:0] RST_VEC     = 16'h0200,
    parameter logic [15:0] IRQ_VEC     = 16'h0300
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  abh,
    input  logic [7:0]  abl,
    input  logic        rw,
    input  logic        sync,
    inout  wire  [7:0]  dataio,
    output logic        dataoe,
    output logic        rdy,
    output logic        buserr,
    output logic [15:0] fetchcnt,
    input  logic        ldwa,
    input  logic [15:0] ldaddr,
    input  logic [7:0]  lddata
);

    localparam int          AW        = $clog2(RAM_DEPTH);
    localparam logic [16:0] RAM_END   = 17'(RAM_DEPTH);
    localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_STATES - 1);

    state_t        state;
    logic [15:0]   addr_q;
    logic          rw_q;
    logic          sync_q;
    logic [2:0]    wait_cnt;

    logic          addr_in_ram;
    logic          ld_in_ram;
    logic          ld_we;
    logic          cpu_we;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic [7:0]    rd_data;
    logic          bad_access;

    assign addr_in_ram = {1'b0, addr_q} < RAM_END;
    assign ld_in_ram   = {1'b0, ldaddr} < RAM_END;

    // Loader owns the single write port on a collision; the CPU write is lost.
    assign ld_we     = ldwa && ld_in_ram;
    assign cpu_we    = (state == ST_ACCESS) && !clr && !rw_q && addr_in_ram;
    assign ram_we    = ld_we || cpu_we;
    assign ram_waddr = ld_we ? ldaddr[AW-1:0] : addr_q[AW-1:0];
    assign ram_wdata = ld_we ? lddata : dataio;

    mem_array #(
        .DEPTH (RAM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (addr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_data = UNMAPPED_DATA;
        if (addr_in_ram) begin
            rd_data = ram_rdata;
        end else if (is_vector(addr_q)) begin
            case ({addr_q[15:1], 1'b0})
                VEC_NMI_ADDR: rd_data = addr_q[0] ? NMI_VEC[15:8] : NMI_VEC[7:0];
                VEC_RST_ADDR: rd_data = addr_q[0] ? RST_VEC[15:8] : RST_VEC[7:0];
                VEC_IRQ_ADDR: rd_data = addr_q[0] ? IRQ_VEC[15:8] : IRQ_VEC[7:0];
                default:      rd_data = UNMAPPED_DATA;
            endcase
        end
    end

    // Reads may hit RAM or the vector ROM; writes may only hit RAM.
    assign bad_access = rw_q ? (!addr_in_ram && !is_vector(addr_q)) : !addr_in_ram;

    assign dataio = dataoe ? rd_data : 8'hzz;

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            rdy      <= 1'b0;
            dataoe   <= 1'b0;
            buserr   <= 1'b0;
            fetchcnt <= 16'h0000;
            wait_cnt <= 3'd0;
            addr_q   <= 16'h0000;
            rw_q     <= 1'b1;
            sync_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    addr_q <= {abh, abl};
                    rw_q   <= rw;
                    sync_q <= sync;
                    if (WAIT_STATES == 0) begin
                        state  <= ST_ACCESS;
                        rdy    <= 1'b1;
                        dataoe <= rw;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state  <= ST_ACCESS;
                        rdy    <= 1'b1;
                        dataoe <= rw_q;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ACCESS: begin
                    state  <= ST_IDLE;
                    rdy    <= 1'b0;
                    dataoe <= 1'b0;
                    if (bad_access) begin
                        buserr <= 1'b1;
                    end
                    if (rw_q && sync_q) begin
                        fetchcnt <= fetchcnt + 16'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    rdy    <= 1'b0;
                    dataoe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder: instance 0 has no wait states, instance 1 has one.
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int          DEPTH = 512;
    localparam logic [15:0] NMI_V = 16'h0200;
    localparam logic [15:0] RST_V = 16'h0200;
    localparam logic [15:0] IRQ_V = 16'h0300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr;
    logic [7:0]  abh [2];
    logic [7:0]  abl [2];
    logic        rw [2];
    logic        sync [2];
    logic        drv_en [2];
    logic [7:0]  drv_data [2];
    logic        ldwa;
    logic [15:0] ldaddr;
    logic [7:0]  lddata;

    wire  [7:0]  dataio0;
    wire  [7:0]  dataio1;
    logic        oe0, oe1, rdy0, rdy1, berr0, berr1;
    logic [15:0] fc0, fc1;

    assign dataio0 = drv_en[0] ? drv_data[0] : 8'hzz;
    assign dataio1 = drv_en[1] ? drv_data[1] : 8'hzz;

    mem_responder #(.RAM_DEPTH(DEPTH), .WAIT_STATES(0),
                    .NMI_VEC(NMI_V), .RST_VEC(RST_V), .IRQ_VEC(IRQ_V)) u_dut0 (
        .clk(clk), .clr(clr), .abh(abh[0]), .abl(abl[0]), .rw(rw[0]), .sync(sync[0]),
        .dataio(dataio0), .dataoe(oe0), .rdy(rdy0), .buserr(berr0), .fetchcnt(fc0),
        .ldwa(ldwa), .ldaddr(ldaddr), .lddata(lddata)
    );

    mem_responder #(.RAM_DEPTH(DEPTH), .WAIT_STATES(1),
                    .NMI_VEC(NMI_V), .RST_VEC(RST_V), .IRQ_VEC(IRQ_V)) u_dut1 (
        .clk(clk), .clr(clr), .abh(abh[1]), .abl(abl[1]), .rw(rw[1]), .sync(sync[1]),
        .dataio(dataio1), .dataoe(oe1), .rdy(rdy1), .buserr(berr1), .fetchcnt(fc1),
        .ldwa(ldwa), .ldaddr(ldaddr), .lddata(lddata)
    );

    // Reference model: byte image per instance, sticky error flag, fetch counter.
    logic [7:0]  mram [2][DEPTH];
    logic        mberr [2];
    logic [15:0] mfc [2];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic obs_rdy(input int d);
        return (d == 1) ? rdy1 : rdy0;
    endfunction
    function automatic logic obs_oe(input int d);
        return (d == 1) ? oe1 : oe0;
    endfunction
    function automatic logic obs_berr(input int d);
        return (d == 1) ? berr1 : berr0;
    endfunction
    function automatic logic [15:0] obs_fc(input int d);
        return (d == 1) ? fc1 : fc0;
    endfunction
    function automatic logic [7:0] obs_data(input int d);
        return (d == 1) ? dataio1 : dataio0;
    endfunction

    function automatic logic in_ram(input logic [15:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic [7:0] model_read(input int d, input logic [15:0] a);
        if (in_ram(a)) return mram[d][a[8:0]];
        case (a)
            16'hFFFA: return NMI_V[7:0];
            16'hFFFB: return NMI_V[15:8];
            16'hFFFC: return RST_V[7:0];
            16'hFFFD: return RST_V[15:8];
            16'hFFFE: return IRQ_V[7:0];
            16'hFFFF: return IRQ_V[15:8];
            default:  return 8'hFF;
        endcase
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            mberr[d] = 1'b0;
            mfc[d]   = 16'h0000;
        end
    endtask

    task automatic idle_inputs(input int d);
        abh[d] = 8'h00; abl[d] = 8'h00; rw[d] = 1'b1; sync[d] = 1'b0;
        drv_en[d] = 1'b0; drv_data[d] = 8'h00;
    endtask

    // Called at a negedge; returns at a negedge where the instance is idle.
    task automatic wait_idle(input int d);
        int k = 0;
        while (!obs_rdy(d) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_val("idle_bound", 32'(k < 20), 32'd1);
        @(negedge clk);
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] v);
        ldwa = 1'b1; ldaddr = a; lddata = v;
        @(negedge clk);
        ldwa = 1'b0;
        if (in_ram(a)) begin
            mram[0][a[8:0]] = v;
            mram[1][a[8:0]] = v;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        check_val("clr_berr0", 32'(berr0), 32'd0);
        check_val("clr_berr1", 32'(berr1), 32'd0);
        check_val("clr_fc1", 32'(fc1), 32'd0);
    endtask

    task automatic xfer(input int d, input logic [15:0] a, input logic r, input logic s,
                        input logic [7:0] wd, input logic collide, input logic [7:0] ldv,
                        output logic [7:0] rd);
        int n = 0;
        int oe_cnt = 0;
        logic [7:0] exp;
        rd = 8'h00;
        wait_idle(d);
        abh[d] = a[15:8]; abl[d] = a[7:0]; rw[d] = r; sync[d] = s;
        drv_en[d] = !r; drv_data[d] = wd;
        exp = model_read(d, a);
        @(posedge clk);
        #1;
        // Bus lines wander after the latch edge; only the latched values matter.
        abh[d] = ~a[15:8]; abl[d] = ~a[7:0]; rw[d] = ~r;
        do begin
            @(negedge clk);
            n++;
            if (obs_oe(d)) begin
                oe_cnt++;
                rd = obs_data(d);
            end
        end while (!obs_rdy(d) && n < 20);
        check_val("latency", 32'(n), 32'(d + 1));
        if (collide) begin
            ldwa = 1'b1; ldaddr = a; lddata = ldv;
        end
        @(negedge clk);
        ldwa = 1'b0;
        check_val("rdy_one_cycle", 32'(obs_rdy(d)), 32'd0);
        if (obs_oe(d)) oe_cnt++;
        check_val("oe_cycles", 32'(oe_cnt), 32'(r));
        if (r) check_val("rdata", 32'(rd), 32'(exp));
        if (r) begin
            if (!in_ram(a) && a < 16'hFFFA) mberr[d] = 1'b1;
            if (s) mfc[d] = mfc[d] + 16'd1;
        end else if (!in_ram(a)) begin
            mberr[d] = 1'b1;
        end else if (!collide) begin
            mram[d][a[8:0]] = wd;
        end
        if (collide && in_ram(a)) begin
            mram[0][a[8:0]] = ldv;
            mram[1][a[8:0]] = ldv;
        end
        check_val("buserr", 32'(obs_berr(d)), 32'(mberr[d]));
        check_val("fetchcnt", 32'(obs_fc(d)), 32'(mfc[d]));
        idle_inputs(d);
    endtask

    task automatic rd_xfer(input int d, input logic [15:0] a, input logic s, output logic [7:0] rd);
        xfer(d, a, 1'b1, s, 8'h00, 1'b0, 8'h00, rd);
    endtask

    task automatic wr_xfer(input int d, input logic [15:0] a, input logic s, input logic [7:0] wd);
        logic [7:0] unused_rd;
        xfer(d, a, 1'b0, s, wd, 1'b0, 8'h00, unused_rd);
    endtask

    initial begin
        logic [7:0] rd;
        logic [15:0] a;
        int d, sel;
        clr = 1'b1; ldwa = 1'b0; ldaddr = 16'h0000; lddata = 8'h00;
        idle_inputs(0);
        idle_inputs(1);
        model_clear();
        @(negedge clk);

        // Loader stays effective while clr is held.
        for (int i = 0; i < DEPTH; i++) load(16'(i), 8'($urandom));
        load(16'h8000, 8'h99);
        check_val("rst_rdy0", 32'(rdy0), 32'd0);
        check_val("rst_rdy1", 32'(rdy1), 32'd0);
        check_val("rst_oe0", 32'(oe0), 32'd0);
        check_val("rst_oe1", 32'(oe1), 32'd0);
        check_val("rst_berr1", 32'(berr1), 32'd0);
        check_val("rst_fc0", 32'(fc0), 32'd0);
        check_val("rst_fc1", 32'(fc1), 32'd0);
        clr = 1'b0;

        load(16'h0005, 8'h42);
        rd_xfer(1, 16'h0005, 1'b0, rd);
        check_val("ram5", 32'(rd), 32'h42);

        wr_xfer(0, 16'h0006, 1'b0, 8'h0F);
        rd_xfer(0, 16'h0006, 1'b0, rd);
        check_val("ram6_ws0", 32'(rd), 32'h0F);
        check_val("ws0_berr", 32'(berr0), 32'd0);

        rd_xfer(1, 16'hFFFC, 1'b0, rd);
        check_val("rstvec_lo", 32'(rd), 32'h00);
        rd_xfer(1, 16'hFFFD, 1'b0, rd);
        check_val("rstvec_hi", 32'(rd), 32'h02);
        wr_xfer(1, 16'hFFFC, 1'b0, 8'h11);
        check_val("vecwr_berr", 32'(berr1), 32'd1);
        rd_xfer(1, 16'hFFFC, 1'b0, rd);
        check_val("rstvec_keep", 32'(rd), 32'h00);

        pulse_clr();
        rd_xfer(1, 16'h8000, 1'b0, rd);
        check_val("unmapped_ff", 32'(rd), 32'hFF);
        rd_xfer(1, 16'h0005, 1'b0, rd);
        check_val("berr_sticky", 32'(berr1), 32'd1);
        pulse_clr();

        rd_xfer(1, 16'h0001, 1'b1, rd);
        rd_xfer(1, 16'hFFFE, 1'b1, rd);
        rd_xfer(1, 16'h0002, 1'b1, rd);
        wr_xfer(1, 16'h0003, 1'b1, 8'h77);
        check_val("fc_three", 32'(fc1), 32'd3);
        wait_idle(1);
        force u_dut1.fetchcnt = 16'hFFFF;
        #1;
        release u_dut1.fetchcnt;
        mfc[1] = 16'hFFFF;
        rd_xfer(1, 16'h0004, 1'b1, rd);
        check_val("fc_wrap", 32'(fc1), 32'd0);

        load(16'h0010, 8'h33);
        wait_idle(1);
        abh[1] = 8'h00; abl[1] = 8'h10; rw[1] = 1'b0; sync[1] = 1'b0;
        drv_en[1] = 1'b1; drv_data[1] = 8'h55;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_in_wait", 32'(rdy1), 32'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        check_val("abort_rdy", 32'(rdy1), 32'd0);
        check_val("abort_oe", 32'(oe1), 32'd0);
        idle_inputs(1);
        rd_xfer(1, 16'h0010, 1'b0, rd);
        check_val("abort_nowrite", 32'(rd), 32'h33);
        xfer(1, 16'h0010, 1'b0, 1'b0, 8'h55, 1'b1, 8'hAA, rd);
        rd_xfer(1, 16'h0010, 1'b0, rd);
        check_val("ld_wins", 32'(rd), 32'hAA);

        for (int i = 0; i < 120; i++) begin
            d = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       a = 16'($urandom_range(0, DEPTH - 1));
            else if (sel < 8)  a = 16'hFFFA + 16'($urandom_range(0, 5));
            else               a = 16'($urandom_range(DEPTH, 32'hFFF9));
            xfer(d, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 7) == 0), 8'($urandom), rd);
            if (i == 60) pulse_clr();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_DEPTH, default 512; RAM size in bytes, mapped at 0x0000..RAM_DEPTH-1.
REQ-002 Parameter WAIT_STATES, default 1, range 0..7; number of WAIT cycles inserted per access.
REQ-003 Parameters NMI_VEC / RST_VEC / IRQ_VEC, defaults 16'h0200 / 16'h0200 / 16'h0300; vector ROM contents.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 clr  input  1  reset; synchronous, active-high.
REQ-006 abh  input  8  CPU address high byte.
REQ-007 abl  input  8  CPU address low byte.
REQ-008 rw  input  1  1 = CPU read, 0 = CPU write.
REQ-009 sync  input  1  high during an opcode-fetch cycle.
REQ-010 dataio  inout  8  shared data bus; driven only while dataoe=1, otherwise high-Z.
REQ-011 dataoe  output  1  high while this block drives dataio.
REQ-012 rdy  output  1  high in the single cycle in which the transfer completes; CPU holds abh/abl/rw/dataio while rdy=0.
REQ-013 buserr  output  1  sticky illegal-access flag.
REQ-014 fetchcnt  output  16  count of completed opcode fetches.
REQ-015 ldwa, ldaddr[15:0], lddata[7:0]  inputs  test preload write port for RAM.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT, ACCESS.
REQ-017 IDLE: on each rising edge, latch {abh,abl}, rw and sync; go to WAIT if WAIT_STATES>0, else to ACCESS.
REQ-018 WAIT: a wait counter loaded with WAIT_STATES-1 decrements each cycle; go to ACCESS when it reaches 0.
REQ-019 ACCESS: lasts exactly one cycle, rdy=1, then return to IDLE; latency from the address-latching edge to rdy = WAIT_STATES+1 cycles.
REQ-020 Reads: in ACCESS, dataoe=1 and dataio = read data for the latched address; dataio is high-Z in all other states.
REQ-021 Read data: RAM byte for RAM addresses; vector ROM for 0xFFFA..0xFFFF, little-endian (FFFA=NMI_VEC[7:0], FFFB=NMI_VEC[15:8], FFFC/D=RST_VEC, FFFE/F=IRQ_VEC); 8'hFF for all other addresses.
REQ-022 Writes: dataio is sampled and RAM is written on the rising edge that ends ACCESS; dataoe stays 0 throughout.
REQ-023 A write to the vector region or an unmapped address SHALL be discarded and SHALL set buserr; a read of an unmapped address SHALL set buserr at the edge ending ACCESS.
REQ-024 buserr SHALL stay set until clr.
REQ-025 fetchcnt SHALL increment at the edge ending ACCESS for a read with latched sync=1; it wraps 0xFFFF -> 0x0000; a write with sync=1 does not count.
REQ-026 ldwa=1 writes lddata to RAM[ldaddr] in any state; ldaddr outside RAM is ignored and does not set buserr.
REQ-027 If ldwa and a CPU RAM write fall on the same edge, the loader write wins, the CPU write is dropped, and the handshake still completes normally.
REQ-028 A change of abh/abl/rw while in WAIT or ACCESS SHALL be ignored; only the latched values are used.

Reset
REQ-029 clr=1 at a rising edge forces state=IDLE, rdy=0, dataoe=0 (dataio high-Z), buserr=0, fetchcnt=0, wait counter=0.
REQ-030 clr during WAIT/ACCESS aborts the access: no RAM write, no counter or flag update.
REQ-031 RAM contents are not reset; ldwa remains effective while clr=1.

Structure
REQ-032 A shared package SHALL hold the state encodings, vector addresses 16'hFFFA/FFFC/FFFE and the unmapped read value 8'hFF.
REQ-033 RAM SHALL be one sub-module, mem_array: single write port (sync write), asynchronous read, parameterised by depth.
REQ-034 The loader/CPU write-port arbitration SHALL sit in mem_responder, outside mem_array.

Verification
REQ-035 WAIT_STATES=1: preload RAM[0x0005]=8'h42, read 0x0005 -> rdy high 2 cycles after the latch edge, dataio=8'h42 with dataoe=1 for exactly one cycle.
REQ-036 WAIT_STATES=0: write 8'h0F to 0x0006, then read 0x0006 -> data 8'h0F; each transfer takes 2 cycles; buserr=0.
REQ-037 Read 0xFFFC then 0xFFFD with RST_VEC=16'h0200 -> 8'h00 then 8'h02; write 8'h11 to 0xFFFC -> buserr=1, next read of 0xFFFC still 8'h00.
REQ-038 Read 0x8000 -> dataio=8'hFF, buserr=1; buserr stays 1 until clr.
REQ-039 Three reads with sync=1 and one write with sync=1 -> fetchcnt=3; force fetchcnt=0xFFFF then one fetch -> 0x0000.
REQ-040 Assert clr in WAIT of a write to 0x0010 -> RAM[0x0010] unchanged, rdy=0, dataio high-Z the next cycle; same-edge ldwa to 0x0010 with 8'hAA vs CPU write 8'h55 -> RAM[0x0010]=8'hAA.
